cmd_parser: RTL

- Command front-end for the timetagger: consumes the host-to-FPGA byte stream delivered by the FX2 OUT-FIFO reader, frames it, and drives the register bank and control strobes (detector/sequencer start/stop).
- Register-read replies go back as a byte stream to the FX2 IN-FIFO writer.
- Sits between the FX2 slave-FIFO interface and the register and control logic.

---
 rtl/cmd_pkg.sv | 28 ++
 rtl/cmd_reply_ser.sv | 32 +++
 rtl/cmd_parser.sv | 119 +++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// cmd_pkg: frame constants, opcodes, control codes and FSM state encoding shared by cmd_parser.
package cmd_pkg;
  localparam logic [7:0] SYNC_BYTE      = 8'hAA;
  localparam int         ADDR_W         = 16;
  localparam int         DATA_W         = 32;
  localparam int         TIMEOUT_CYCLES = 1024;
  localparam logic [7:0] OP_CTRL        = 8'h01;
  localparam logic [7:0] OP_RD          = 8'h03;
  localparam logic [7:0] OP_WR          = 8'h05;
  localparam logic [7:0] TGT_DET        = 8'h01;
  localparam logic [7:0] TGT_SEQ        = 8'h02;
  localparam logic [7:0] ACT_START      = 8'h01;
  localparam logic [7:0] ACT_STOP       = 8'h02;
  localparam logic [2:0] N_CTRL         = 3'd2;
  localparam logic [2:0] N_RD           = 3'd2;
  localparam logic [2:0] N_WR           = 3'd6;
  localparam logic [2:0] REPLY_LEN      = 3'd6;

  typedef enum logic [2:0] {S_IDLE, S_OPCODE, S_ARGS, S_ISSUE, S_WAIT_RD, S_REPLY} state_t;

  function automatic logic is_op(input logic [7:0] op);
    return op == OP_CTRL || op == OP_RD || op == OP_WR;
  endfunction

  function automatic logic [2:0] arg_count(input logic [7:0] op);
    return op == OP_WR ? N_WR : op == OP_RD ? N_RD : N_CTRL;
  endfunction
endpackage

// File: rtl/cmd_reply_ser.sv
// cmd_reply_ser: serializes a read reply (SYNC, OP_RD, 4 data bytes LSB first) over valid/ready.
module cmd_reply_ser
  import cmd_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic [7:0]        o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_done
);
  logic [47:0] r_sh;
  logic [2:0]  r_left;

  assign o_data  = r_sh[7:0];
  assign o_valid = r_left != 3'd0;
  assign o_done  = o_valid && i_ready && r_left == 3'd1;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_sh   <= '0;
      r_left <= '0;
    end else if (i_load) begin
      r_sh   <= {i_data, OP_RD, SYNC_BYTE};
      r_left <= REPLY_LEN;
    end else if (o_valid && i_ready) begin
      r_sh   <= {8'h00, r_sh[47:8]};
      r_left <= r_left - 3'd1;
    end
endmodule

// File: rtl/cmd_parser.sv
// cmd_parser: frames the host command byte stream into register reads/writes and control strobes.
// Define CMD_PARSER_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYCLES between bytes.
module cmd_parser
  import cmd_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        ctrl_target,
  output logic [7:0]        ctrl_action,
  output logic              ctrl_stb,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_wr,
  output logic              reg_rd,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_rd_ack,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        err_count,
  output logic              busy
);
  state_t      r_state, w_next;
  logic [7:0]  r_op;
  logic [2:0]  r_left;
  logic [47:0] r_sh;
  logic [47:0] w_sh;
  logic        w_acc, w_bad, w_last, w_to, w_load, w_done, w_mid;

  assign w_mid  = r_state == S_OPCODE || r_state == S_ARGS;
  assign w_acc  = in_valid && in_ready;
  assign w_bad  = r_state == S_OPCODE && w_acc && !is_op(in_data);
  assign w_last = r_state == S_ARGS && w_acc && r_left == 3'd1;
  assign w_load = r_state == S_WAIT_RD && reg_rd_ack;
  // Arguments shift in from the top: a 6-byte frame ends LSB-first in [47:0], a 2-byte one in [47:32].
  assign w_sh   = {in_data, r_sh[47:8]};

`ifdef CMD_PARSER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] r_idle;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_idle <= '0;
    else r_idle <= (w_acc || !w_mid) ? '0 : r_idle + 1'b1;
  assign w_to = w_mid && !w_acc && r_idle == TW'(TIMEOUT_CYCLES - 1);
`else
  assign w_to = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    w_next = (w_acc && in_data == SYNC_BYTE) ? S_OPCODE : S_IDLE;
      S_OPCODE:  w_next = w_to ? S_IDLE : !w_acc ? S_OPCODE : is_op(in_data) ? S_ARGS : S_IDLE;
      S_ARGS:    w_next = w_to ? S_IDLE : w_last ? S_ISSUE : S_ARGS;
      S_ISSUE:   w_next = r_op == OP_RD ? S_WAIT_RD : S_IDLE;
      S_WAIT_RD: w_next = reg_rd_ack ? S_REPLY : S_WAIT_RD;
      S_REPLY:   w_next = w_done ? S_IDLE : S_REPLY;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = reset_n && (r_state == S_IDLE || w_mid);
    ctrl_stb = r_state == S_ISSUE && r_op == OP_CTRL;
    reg_wr   = r_state == S_ISSUE && r_op == OP_WR;
    reg_rd   = (r_state == S_ISSUE && r_op == OP_RD) || r_state == S_WAIT_RD;
    busy     = r_state != S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_op        <= '0;
      r_left      <= '0;
      r_sh        <= '0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      ctrl_target <= '0;
      ctrl_action <= '0;
      err_count   <= '0;
    end else begin
      if (r_state == S_OPCODE && w_acc) begin
        r_op   <= in_data;
        r_left <= arg_count(in_data);
      end
      if (r_state == S_ARGS && w_acc) begin
        r_sh   <= w_sh;
        r_left <= r_left - 3'd1;
      end
      // Outputs commit only on the final byte so aborted frames leave them untouched.
      if (w_last && r_op == OP_WR) begin
        reg_addr  <= w_sh[15:0];
        reg_wdata <= w_sh[47:16];
      end
      if (w_last && r_op == OP_RD) reg_addr <= w_sh[47:32];
      if (w_last && r_op == OP_CTRL) begin
        ctrl_target <= w_sh[39:32];
        ctrl_action <= w_sh[47:40];
      end
      if ((w_bad || w_to) && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end

  cmd_reply_ser u_ser (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_data  (reg_rdata),
    .o_data  (out_data),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_done  (w_done)
  );
endmodule
